// File: rtl/bsg_fsb_murn_pkg.sv
// Shared definitions for the FSB murn gateway: the command opcodes and the
// field layout of a ring packet (dest id at the top, then the cmd flag, and
// the opcode in the low bits of command packets).
package bsg_fsb_murn_pkg;

  typedef enum logic [2:0] {
    OP_NOP         = 3'b000,
    OP_ENABLE      = 3'b001,
    OP_DISABLE     = 3'b010,
    OP_RESET_ON    = 3'b011,
    OP_RESET_OFF   = 3'b100,
    OP_RESET_PULSE = 3'b101
  } murn_opcode_e;

  localparam int opcode_lsb_lp   = 0;
  localparam int opcode_width_lp = 3;

  // Most significant bit of the destination id field.
  function automatic int murn_id_msb(input int ring_width);
    return ring_width - 1;
  endfunction

  // The cmd flag sits directly below the destination id field.
  function automatic int murn_cmd_bit(input int ring_width, input int id_width);
    return ring_width - 1 - id_width;
  endfunction

endpackage

// File: rtl/bsg_fsb_murn_node_ctrl.sv
// Per-node control: enable flag, reset flag and the down-counter that times
// reset pulses. Commands take effect at the next clock edge; a level command
// (assert/deassert reset) cancels any pulse in flight, and a new pulse
// restarts the count from the full length.
module bsg_fsb_murn_node_ctrl
  import bsg_fsb_murn_pkg::*;
#(
  parameter int pulse_cycles_p = 16
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         cmd_v_i,
  input  murn_opcode_e opcode_i,
  output logic         en_r_o,
  output logic         reset_r_o
);

  localparam int cnt_w_lp = $clog2(pulse_cycles_p + 1);
  localparam logic [cnt_w_lp-1:0] pulse_init_lp = cnt_w_lp'(pulse_cycles_p);
  localparam logic [cnt_w_lp-1:0] cnt_one_lp    = cnt_w_lp'(1);

  logic                en_q, en_d;
  logic                rst_q, rst_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;

  // Next state: the pulse counter ticks down and releases reset on its last
  // cycle; an incoming command overrides whatever the counter would do.
  always_comb begin
    en_d  = en_q;
    rst_d = rst_q;
    cnt_d = cnt_q;
    if (cnt_q == cnt_one_lp) begin
      rst_d = 1'b0;
      cnt_d = '0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - cnt_one_lp;
    end
    if (cmd_v_i) begin
      case (opcode_i)
        OP_ENABLE:      en_d = 1'b1;
        OP_DISABLE:     en_d = 1'b0;
        OP_RESET_ON: begin
          rst_d = 1'b1;
          cnt_d = '0;
        end
        OP_RESET_OFF: begin
          rst_d = 1'b0;
          cnt_d = '0;
        end
        OP_RESET_PULSE: begin
          rst_d = 1'b1;
          cnt_d = pulse_init_lp;
        end
        default: ;
      endcase
    end
  end

  // State registers; the node is held disabled and in reset while reset_i is high.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      en_q  <= 1'b0;
      rst_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      en_q  <= en_d;
      rst_q <= rst_d;
      cnt_q <= cnt_d;
    end
  end

  assign en_r_o    = en_q;
  assign reset_r_o = rst_q;

endmodule

// File: rtl/bsg_fsb_murn_gateway_multi.sv
// Ring gateway serving several local nodes. Packets for other ids and all
// command packets are consumed immediately; data for an enabled node goes
// through a one-entry output buffer shared by all nodes, data for a disabled
// node is dropped and counted.
module bsg_fsb_murn_gateway_multi
  import bsg_fsb_murn_pkg::*;
#(
  parameter int ring_width_p   = 80,
  parameter int id_width_p     = 4,
  parameter int num_nodes_p    = 4,
  parameter int base_id_p      = 0,
  parameter int pulse_cycles_p = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    v_i,
  input  logic [ring_width_p-1:0] data_i,
  output logic                    ready_o,
  output logic [num_nodes_p-1:0]  v_o,
  output logic [ring_width_p-1:0] data_o,
  input  logic [num_nodes_p-1:0]  ready_i,
  output logic [num_nodes_p-1:0]  node_en_r_o,
  output logic [num_nodes_p-1:0]  node_reset_r_o,
  output logic [15:0]             drop_count_o
);

  localparam int idx_w_lp   = (num_nodes_p > 1) ? $clog2(num_nodes_p) : 1;
  localparam int id_msb_lp  = murn_id_msb(ring_width_p);
  localparam int cmd_bit_lp = murn_cmd_bit(ring_width_p, id_width_p);

  logic [id_width_p-1:0] dest_id;
  logic [31:0]           id_offset;
  logic                  hit;
  logic [idx_w_lp-1:0]   local_idx;
  logic                  is_cmd;
  murn_opcode_e          opcode;
  logic                  target_en;
  logic                  deq;
  logic                  space;
  logic                  enq;
  logic                  drop;

  logic                    buf_v_q, buf_v_d;
  logic [ring_width_p-1:0] buf_data_q, buf_data_d;
  logic [idx_w_lp-1:0]     buf_dest_q, buf_dest_d;
  logic [15:0]             drop_q, drop_d;

  // Ids below the base wrap to huge offsets, so one unsigned compare covers both bounds.
  assign dest_id   = data_i[id_msb_lp -: id_width_p];
  assign id_offset = 32'(dest_id) - 32'(base_id_p);
  assign hit       = v_i & (id_offset < 32'(num_nodes_p));
  assign local_idx = id_offset[idx_w_lp-1:0];
  assign is_cmd    = data_i[cmd_bit_lp];
  assign opcode    = murn_opcode_e'(data_i[opcode_lsb_lp +: opcode_width_lp]);
  assign target_en = node_en_r_o[local_idx];

  genvar k;
  generate
    for (k = 0; k < num_nodes_p; k++) begin : g_node
      logic cmd_v;
      assign cmd_v = hit & is_cmd & (local_idx == idx_w_lp'(k));
      bsg_fsb_murn_node_ctrl #(
        .pulse_cycles_p(pulse_cycles_p)
      ) u_ctrl (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .cmd_v_i   (cmd_v),
        .opcode_i  (opcode),
        .en_r_o    (node_en_r_o[k]),
        .reset_r_o (node_reset_r_o[k])
      );
    end
  endgenerate

  // One-hot valid for the buffered packet's destination.
  always_comb begin
    v_o = '0;
    for (int n = 0; n < num_nodes_p; n++) begin
      if (buf_v_q && (buf_dest_q == idx_w_lp'(n))) v_o[n] = 1'b1;
    end
  end

  // Since v_o is one-hot, only the addressed ready_i bit can complete a transfer.
  assign deq   = |(v_o & ready_i);
  assign space = ~buf_v_q | deq;
  assign enq   = hit & ~is_cmd & target_en & space;
  assign drop  = hit & ~is_cmd & ~target_en;

  // Foreign and command packets never stall; only data for an enabled node waits for buffer space.
  always_comb begin
    ready_o = 1'b0;
    if (v_i && !reset_i) begin
      ready_o = ~hit | is_cmd | ~target_en | space;
    end
  end

  // Buffer and drop counter next state; a simultaneous dequeue and enqueue keeps full throughput.
  always_comb begin
    buf_v_d    = buf_v_q;
    buf_data_d = buf_data_q;
    buf_dest_d = buf_dest_q;
    drop_d     = drop_q;
    if (enq) begin
      buf_v_d    = 1'b1;
      buf_data_d = data_i;
      buf_dest_d = local_idx;
    end else if (deq) begin
      buf_v_d = 1'b0;
    end
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  // Buffer and counter registers; reset discards any buffered packet.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      buf_v_q    <= 1'b0;
      buf_data_q <= '0;
      buf_dest_q <= '0;
      drop_q     <= '0;
    end else begin
      buf_v_q    <= buf_v_d;
      buf_data_q <= buf_data_d;
      buf_dest_q <= buf_dest_d;
      drop_q     <= drop_d;
    end
  end

  assign data_o       = buf_data_q;
  assign drop_count_o = drop_q;

endmodule

// File: tb/tb_bsg_fsb_murn_gateway_multi.sv
// Scoreboard bench for the murn gateway: stimulus pushes expected deliveries
// into a queue, a negedge monitor pops and compares each completed transfer.
module tb_bsg_fsb_murn_gateway_multi;
  import bsg_fsb_murn_pkg::*;

  logic        clk;
  logic        reset_i;
  logic        v_i;
  logic [79:0] data_i;
  logic        ready_o;
  logic [3:0]  v_o;
  logic [79:0] data_o;
  logic [3:0]  ready_i;
  logic [3:0]  node_en_r_o;
  logic [3:0]  node_reset_r_o;
  logic [15:0] drop_count_o;

  typedef struct {
    logic [3:0]  vec;
    logic [79:0] pkt;
  } expT;

  expT expQ[$];
  expT monE;
  int  checkCount = 0;
  int  passCount  = 0;
  logic countEn = 1'b0;
  int  pulseHigh;

  bsg_fsb_murn_gateway_multi #(
    .ring_width_p(80),
    .id_width_p(4),
    .num_nodes_p(4),
    .base_id_p(0),
    .pulse_cycles_p(16)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .v_i            (v_i),
    .data_i         (data_i),
    .ready_o        (ready_o),
    .v_o            (v_o),
    .data_o         (data_o),
    .ready_i        (ready_i),
    .node_en_r_o    (node_en_r_o),
    .node_reset_r_o (node_reset_r_o),
    .drop_count_o   (drop_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against the bench's expected value.
  task automatic checkOutput(input string name, input logic [79:0] actual, input logic [79:0] expected);
    checkCount++;
    if (actual !== expected)
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    else
      passCount++;
  endtask

  function automatic logic [79:0] mkPkt(input logic [3:0] id, input logic cmd, input logic [74:0] body);
    return {id, cmd, body};
  endfunction

  function automatic logic [79:0] cmdPkt(input logic [3:0] id, input murn_opcode_e op);
    return mkPkt(id, 1'b1, 75'(op));
  endfunction

  // Present one packet, wait (bounded) for it to be consumed, report the stall cycles.
  task automatic applyStimulus(input logic [79:0] pkt, output int waits);
    v_i    = 1'b1;
    data_i = pkt;
    waits  = 0;
    @(negedge clk);
    while (!ready_o && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (waits >= 50) checkOutput("accept_timeout", 80'(ready_o), 80'(1));
    @(posedge clk);
    #1;
    v_i = 1'b0;
  endtask

  // Wait for node 3's reset to drop and return how many cycles it was high.
  task automatic measurePulse(output int highCycles);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!node_reset_r_o[3]) break;
    end
    #1;
    highCycles = pulseHigh;
    countEn = 1'b0;
  endtask

  // Count negedges with node 3 held in reset while counting is armed.
  always @(negedge clk) begin
    if (!countEn) pulseHigh = 0;
    else if (node_reset_r_o[3]) pulseHigh++;
  end

  // Monitor: every completed output transfer must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset_i && ((v_o & ready_i) != 4'b0)) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected_out", 80'(v_o), 80'(0));
      end else begin
        monE = expQ.pop_front();
        checkOutput("out_valid", 80'(v_o), 80'(monE.vec));
        checkOutput("out_data", data_o, monE.pkt);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w;
    int hi;
    logic [79:0] pkt;

    reset_i = 1'b1;
    v_i     = 1'b1;
    data_i  = mkPkt(4'd9, 1'b0, 75'h1);
    ready_i = 4'b0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_en", 80'(node_en_r_o), 80'(4'b0000));
    checkOutput("rst_nodereset", 80'(node_reset_r_o), 80'(4'b1111));
    checkOutput("rst_vo", 80'(v_o), 80'(4'b0000));
    checkOutput("rst_drop", 80'(drop_count_o), 80'(0));
    checkOutput("rst_ready", 80'(ready_o), 80'(0));
    @(posedge clk);
    #1;
    v_i     = 1'b0;
    reset_i = 1'b0;

    // First command straight after reset, then a data packet to disabled node 2.
    applyStimulus(cmdPkt(4'd0, OP_ENABLE), w);
    checkOutput("first_cmd_wait", 80'(w), 80'(0));
    checkOutput("en_node0", 80'(node_en_r_o), 80'(4'b0001));
    applyStimulus(mkPkt(4'd2, 1'b0, 75'h55), w);
    checkOutput("drop_wait", 80'(w), 80'(0));
    checkOutput("drop_vo", 80'(v_o), 80'(4'b0000));
    checkOutput("drop_count1", 80'(drop_count_o), 80'(1));

    // Enable node 2, send 0xABCD, hold it while ready_i[2] is low.
    applyStimulus(cmdPkt(4'd2, OP_ENABLE), w);
    checkOutput("en_node2", 80'(node_en_r_o), 80'(4'b0101));
    pkt = mkPkt(4'd2, 1'b0, 75'hABCD);
    expQ.push_back('{vec: 4'b0100, pkt: pkt});
    applyStimulus(pkt, w);
    @(negedge clk);
    checkOutput("lat1_vo", 80'(v_o), 80'(4'b0100));
    checkOutput("lat1_data", 80'(data_o[15:0]), 80'(16'hABCD));
    ready_i = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("hold_vo", 80'(v_o), 80'(4'b0100));
      checkOutput("hold_data", data_o, pkt);
    end

    // Disabling node 2 must not flush its buffered packet.
    applyStimulus(cmdPkt(4'd2, OP_DISABLE), w);
    checkOutput("disable_wait", 80'(w), 80'(0));
    checkOutput("dis_node2", 80'(node_en_r_o), 80'(4'b0001));
    checkOutput("dis_keep_vo", 80'(v_o), 80'(4'b0100));
    ready_i = 4'b0100;
    @(posedge clk);
    #1;
    ready_i = 4'b0000;
    @(negedge clk);
    checkOutput("drained_vo", 80'(v_o), 80'(4'b0000));

    // Back-to-back traffic to nodes 0 and 1 with all readies high.
    applyStimulus(cmdPkt(4'd1, OP_ENABLE), w);
    checkOutput("en_node1", 80'(node_en_r_o), 80'(4'b0011));
    ready_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      pkt = mkPkt(4'(i % 2), 1'b0, 75'(32'h1000 + i));
      expQ.push_back('{vec: 4'(1 << (i % 2)), pkt: pkt});
      applyStimulus(pkt, w);
      checkOutput("b2b_wait", 80'(w), 80'(0));
    end
    repeat (3) @(negedge clk);

    // Foreign id 9: consumed at once, nothing changes.
    applyStimulus(mkPkt(4'd9, 1'b0, 75'h77), w);
    checkOutput("foreign_wait", 80'(w), 80'(0));
    checkOutput("foreign_vo", 80'(v_o), 80'(4'b0000));
    checkOutput("foreign_drop", 80'(drop_count_o), 80'(1));
    checkOutput("foreign_en", 80'(node_en_r_o), 80'(4'b0011));

    // Reset pulses on node 3.
    applyStimulus(cmdPkt(4'd3, OP_RESET_OFF), w);
    checkOutput("rstoff_node3", 80'(node_reset_r_o), 80'(4'b0111));
    applyStimulus(cmdPkt(4'd3, OP_RESET_PULSE), w);
    countEn = 1'b1;
    measurePulse(hi);
    checkOutput("pulse_len16", 80'(hi), 80'(16));
    applyStimulus(cmdPkt(4'd3, OP_RESET_PULSE), w);
    countEn = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    applyStimulus(cmdPkt(4'd3, OP_RESET_PULSE), w);
    measurePulse(hi);
    checkOutput("pulse_len24", 80'(hi), 80'(24));

    // Assert-reset during a pulse cancels it; deassert clears next edge.
    applyStimulus(cmdPkt(4'd3, OP_RESET_PULSE), w);
    repeat (3) @(posedge clk);
    #1;
    applyStimulus(cmdPkt(4'd3, OP_RESET_ON), w);
    repeat (20) @(negedge clk);
    checkOutput("cancel_held", 80'(node_reset_r_o[3]), 80'(1));
    applyStimulus(cmdPkt(4'd3, OP_RESET_OFF), w);
    checkOutput("cancel_clear", 80'(node_reset_r_o), 80'(4'b0111));

    // Drop counter saturation against disabled node 2.
    v_i    = 1'b1;
    data_i = mkPkt(4'd2, 1'b0, 75'h99);
    repeat (65533) @(posedge clk);
    #1;
    v_i = 1'b0;
    checkOutput("drop_fffe", 80'(drop_count_o), 80'(16'hFFFE));
    v_i = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    v_i = 1'b0;
    checkOutput("drop_sat", 80'(drop_count_o), 80'(16'hFFFF));

    // Reset with a packet for node 1 buffered: discarded, never delivered.
    ready_i = 4'b0000;
    applyStimulus(mkPkt(4'd1, 1'b0, 75'h1111), w);
    @(negedge clk);
    checkOutput("pre_rst_vo", 80'(v_o), 80'(4'b0010));
    v_i    = 1'b1;
    data_i = mkPkt(4'd0, 1'b0, 75'h2222);
    #2;
    reset_i = 1'b1;
    #1;
    checkOutput("midrst_vo", 80'(v_o), 80'(4'b0000));
    checkOutput("midrst_nodereset", 80'(node_reset_r_o), 80'(4'b1111));
    checkOutput("midrst_en", 80'(node_en_r_o), 80'(4'b0000));
    checkOutput("midrst_drop", 80'(drop_count_o), 80'(0));
    checkOutput("midrst_ready", 80'(ready_o), 80'(0));
    v_i = 1'b0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    ready_i = 4'b1111;
    repeat (5) @(negedge clk);
    checkOutput("post_rst_vo", 80'(v_o), 80'(4'b0000));
    checkOutput("queue_empty", 80'(expQ.size()), 80'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/bsg_fsb_murn_gateway_multi.md
BSG_FSB_MURN_GATEWAY_MULTI -- requirements
Module: bsg_fsb_murn_gateway_multi

Interface
REQ-001 SHALL have parameter ring_width_p, default 80: width of one ring packet.
REQ-002 SHALL have parameter id_width_p, default 4: width of the destination-id field.
REQ-003 SHALL have parameter num_nodes_p, default 4: number of local nodes served (1..2**id_width_p).
REQ-004 SHALL have parameter base_id_p, default 0: id of local node 0; node k owns id base_id_p+k.
REQ-005 SHALL have parameter pulse_cycles_p, default 16: node-reset pulse length in cycles (>=1).
REQ-006 SHALL have port clk_i  input  1  the single clock.
REQ-007 SHALL have port reset_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port v_i  input  1  inbound packet valid.
REQ-009 SHALL have port data_i  input  ring_width_p  inbound packet: [msb -: id_width_p] dest id, next bit cmd flag, [2:0] opcode when cmd=1.
REQ-010 SHALL have port ready_o  output  1  inbound packet consumed this cycle.
REQ-011 SHALL have port v_o  output  num_nodes_p  one-hot output valid, bit k = packet for node k.
REQ-012 SHALL have port data_o  output  ring_width_p  buffered packet, shared by all nodes.
REQ-013 SHALL have port ready_i  input  num_nodes_p  per-node output ready.
REQ-014 SHALL have port node_en_r_o  output  num_nodes_p  registered per-node enable.
REQ-015 SHALL have port node_reset_r_o  output  num_nodes_p  registered per-node reset.
REQ-016 SHALL have port drop_count_o  output  16  saturating count of data packets dropped for disabled nodes.

Function
REQ-017 Hit: v_i and dest id in [base_id_p, base_id_p+num_nodes_p-1], local index k = id-base_id_p; all other packets are foreign.
REQ-018 Foreign packets SHALL be consumed (ready_o=1) in the same cycle and discarded.
REQ-019 Command packet (hit, cmd=1) SHALL be consumed in the same cycle, never forwarded; opcodes: 001 enable, 010 disable, 011 assert reset, 100 deassert reset, 101 reset pulse; others consumed, no effect.
REQ-020 Command effects SHALL be visible on node_*_r_o at the next clock edge.
REQ-021 Reset pulse SHALL set node_reset_r_o[k]=1 for exactly pulse_cycles_p cycles, then clear it, via a per-node down-counter.
REQ-022 Pulse received while a pulse is active on the same node SHALL restart the count at pulse_cycles_p.
REQ-023 Opcode 011 or 100 during a pulse SHALL cancel the counter; reset then stays 1 (011) or clears next edge (100).
REQ-024 Data packet (hit, cmd=0) to a disabled node SHALL be consumed and dropped, incrementing drop_count_o, saturating at 16'hFFFF.
REQ-025 Data packet to an enabled node SHALL enter a one-entry output buffer; ready_o = buffer empty OR (v_o[j] and ready_i[j]) for buffered destination j.
REQ-026 Buffered packet SHALL appear on data_o/v_o the cycle after acceptance (latency 1); full throughput of one packet per cycle when ready_i held high.
REQ-027 Buffer SHALL hold data_o and v_o stable until the addressed ready_i bit is high.
REQ-028 Disable or reset command to node j while buffer holds a packet for j SHALL NOT flush it; packet is still delivered.
REQ-029 ready_o SHALL be 0 whenever v_i is 0.
REQ-030 ready_i bits of non-addressed nodes SHALL be ignored.

Reset
REQ-031 While reset_i=1: node_en_r_o=0, node_reset_r_o=all ones, v_o=0, drop_count_o=0, pulse counters=0, buffer empty, ready_o=0.
REQ-032 Reset asserted mid-transfer SHALL discard the buffered packet without delivery.
REQ-033 First command SHALL be accepted in the first cycle after reset_i deasserts.

Structure
REQ-034 Opcode enum and packet field-offset localparams SHALL live in shared package bsg_fsb_murn_pkg.
REQ-035 Per-node enable/reset/pulse logic SHALL be sub-module bsg_fsb_murn_node_ctrl, instantiated num_nodes_p times in a generate loop.
REQ-036 Output buffer and drop counter SHALL be in the top module.

Verification
REQ-037 After reset, send id 2 data with node 2 disabled -> ready_o=1, v_o=0 always, drop_count_o 0->1.
REQ-038 Enable node 2 (opcode 001), send data 0xABCD to id 2 -> next cycle v_o=4'b0100, data_o=0xABCD; held while ready_i[2]=0.
REQ-039 Back-to-back packets to nodes 0 and 1, ready_i=4'b1111 -> one packet per cycle, ready_o continuously 1.
REQ-040 Pulse opcode to node 3, pulse_cycles_p=16 -> node_reset_r_o[3]=1 for 16 cycles; repeat at cycle 8 -> high for 24 cycles total.
REQ-041 Packet to id 9 (foreign) -> ready_o=1, no state change; 65540 drops -> drop_count_o=16'hFFFF.
REQ-042 Assert reset_i with buffer full, v_o[1]=1 -> v_o=0 immediately, node_reset_r_o=4'b1111.
